// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: control codes, FSM states and
// small op-decoding helpers.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // SUB and SLT both compute A + ~B + 1
  function automatic logic op_subtracts(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic op_valid(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_1.sv
// One-bit MIPS ALU slice: full adder plus the bitwise logic results and
// propagate/generate terms.
module alu_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout,
  output logic y_and,
  output logic y_or,
  output logic y_xor,
  output logic y_nor,
  output logic p,
  output logic g
);

  assign y_and = a & b;
  assign y_or  = a | b;
  assign y_xor = a ^ b;
  assign y_nor = ~(a | b);
  assign p     = a | b;
  assign g     = a & b;
  assign sum   = a ^ b ^ cin;
  assign cout  = g | (p & cin);

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: one alu_1 slice iterated LSB-first over WIDTH cycles,
// with flags reconstructed on the last bit and a one-cycle done pulse.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] rs;
  logic [3:0]       op_q;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             accept, last;

  logic s_sum, s_cout, s_and, s_or, s_xor, s_nor, s_p, s_g;
  logic unused_pg;

  alu_1 u_slice (
    .a     (sa[0]),
    .b     (sb[0]),
    .cin   (cy),
    .sum   (s_sum),
    .cout  (s_cout),
    .y_and (s_and),
    .y_or  (s_or),
    .y_xor (s_xor),
    .y_nor (s_nor),
    .p     (s_p),
    .g     (s_g)
  );
  assign unused_pg = s_p ^ s_g;

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last    = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  logic             bit_sel;
  logic [WIDTH-1:0] full;
  logic [WIDTH-1:0] fin;
  logic             ovf_raw, fin_co, fin_ov;

  always_comb begin
    case (op_q)
      OP_AND:                 bit_sel = s_and;
      OP_OR:                  bit_sel = s_or;
      OP_XOR:                 bit_sel = s_xor;
      OP_NOR:                 bit_sel = s_nor;
      OP_ADD, OP_SUB, OP_SLT: bit_sel = s_sum;
      default:                bit_sel = 1'b0;
    endcase
  end

  assign full    = {bit_sel, rs};
  // On the MSB cycle cy is the carry into the MSB, s_cout the carry out of it
  assign ovf_raw = cy ^ s_cout;

  always_comb begin
    fin    = full;
    fin_co = 1'b0;
    fin_ov = 1'b0;
    if (!op_valid(op_q)) begin
      fin = '0;
    end else if (op_q == OP_SLT) begin
      fin    = '0;
      fin[0] = s_sum ^ ovf_raw;
    end else if (op_q == OP_ADD || op_q == OP_SUB) begin
      fin_co = s_cout;
      fin_ov = ovf_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa        <= '0;
      sb        <= '0;
      rs        <= '0;
      op_q      <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      sa   <= a;
      sb   <= op_subtracts(op) ? ~b : b;
      op_q <= op;
      cy   <= op_subtracts(op);
      cnt  <= '0;
    end else if (busy) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      rs  <= full[WIDTH-1:1];
      cy  <= s_cout;
      cnt <= cnt + CW'(1);
      if (last) begin
        result    <= fin;
        zero      <= (fin == '0);
        carry_out <= fin_co;
        overflow  <= fin_ov;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Directed self-checking bench for alu_serial with hand-computed vectors.
module tb_alu_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'b0000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zero, carry_out, overflow;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_serial #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Issue one op and wait for done; lat = edges from start edge to done, -1 on timeout.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 2; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i - 1 + 1;
        break;
      end
    end
    if (lat > 0) lat = lat;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero got %b want 0", zero); end
    n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL reset_carry got %b want 0", carry_out); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    int lat;
    do_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL add_latency got %0d want 33", lat); end
    n_cmp++; if (result !== 32'h8000_0000) begin n_bad++; $display("FAIL add_result got %h want 80000000", result); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL add_ovf got %b want 1", overflow); end
    n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL add_carry got %b want 0", carry_out); end
    n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL add_zero got %b want 0", zero); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL add_busy_in_done got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse got %b want 0", done); end
    n_cmp++; if (result !== 32'h8000_0000) begin n_bad++; $display("FAIL add_hold got %h want 80000000", result); end
  endtask

  task automatic test_sub_zero();
    int lat;
    do_op(4'b0110, 32'h0000_0005, 32'h0000_0005, lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL sub_latency got %0d want 33", lat); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL sub_result got %h want 0", result); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL sub_zero got %b want 1", zero); end
    n_cmp++; if (carry_out !== 1'b1) begin n_bad++; $display("FAIL sub_carry got %b want 1", carry_out); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sub_ovf got %b want 0", overflow); end
  endtask

  task automatic test_slt();
    int lat;
    do_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    n_cmp++; if (result !== 32'h1) begin n_bad++; $display("FAIL slt_neg_result got %h want 1", result); end
    n_cmp++; if (carry_out !== 1'b0 || overflow !== 1'b0) begin n_bad++;
      $display("FAIL slt_neg_flags got c=%b v=%b want 0 0", carry_out, overflow); end
    do_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, lat);
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL slt_ovf_result got %h want 0", result); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL slt_ovf_zero got %b want 1", zero); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL slt_ovf_flag got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int lat;
    @(negedge clk);
    start = 1'b1; op = 4'b1100; a = 32'h0; b = 32'h0;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    repeat (9) begin @(posedge clk); cyc++; end
    #1 start = 1'b1; op = 4'b0000; a = 32'h1234_5678; b = 32'h0000_FFFF;
    @(posedge clk); cyc++;
    #1 start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ignore_busy got %b want 1", busy); end
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin lat = cyc; break; end
      @(posedge clk); cyc++;
      #1;
    end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL ignore_latency got %0d want 33", lat); end
    n_cmp++; if (result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL nor_result got %h want ffffffff", result); end
    start = 1'b1; op = 4'b0000; a = 32'h00FF_F0F0; b = 32'hFF00_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++;
      $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done); end
    n_cmp++; if (result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL b2b_hold got %h want ffffffff", result); end
    cyc = 1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); cyc++;
      #1;
      if (done) begin lat = cyc; break; end
    end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_latency got %0d want 33", lat); end
    n_cmp++; if (result !== 32'h0000_F0F0) begin n_bad++; $display("FAIL and_result got %h want 0000f0f0", result); end
  endtask

  task automatic test_reset_midrun();
    int lat;
    logic seen_done;
    @(negedge clk);
    start = 1'b1; op = 4'b0010; a = 32'h1111_1111; b = 32'h2222_2222;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL midrst_result got %h want 0", result); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done got %b want 0", seen_done); end
    do_op(4'b0010, 32'h3, 32'h4, lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL post_rst_latency got %0d want 33", lat); end
    n_cmp++; if (result !== 32'h7) begin n_bad++; $display("FAIL post_rst_add got %h want 7", result); end
  endtask

  task automatic test_invalid_op();
    int lat;
    do_op(4'b0101, 32'hDEAD_BEEF, 32'h1234_5678, lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL inv_latency got %0d want 33", lat); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL inv_result got %h want 0", result); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL inv_zero got %b want 1", zero); end
    n_cmp++; if (overflow !== 1'b0 || carry_out !== 1'b0) begin n_bad++;
      $display("FAIL inv_flags got c=%b v=%b want 0 0", carry_out, overflow); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_slt();
    test_back_to_back();
    test_reset_midrun();
    test_invalid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
